// File: rtl/hs32_mem_arbiter.sv
// HS32 two-master memory arbiter: fetch and execute share one bus.
// Execute has priority, bounded by a fetch starvation guard.
module hs32_mem_arbiter #(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addrf,
  input  logic        stbf,
  output logic [31:0] dtrf,
  output logic        ackf,
  output logic        stlf,
  input  logic [31:0] addre,
  input  logic [31:0] dtwe,
  input  logic        rwe,
  input  logic        stbe,
  output logic [31:0] dtre,
  output logic        acke,
  output logic        stle,
  output logic [31:0] addr,
  output logic [31:0] dtw,
  output logic        rw,
  output logic        stb,
  input  logic [31:0] dtr,
  input  logic        ack,
  input  logic        stl
);

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic {OWN_F, OWN_E} own_t;

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  state_t      state, state_n;
  own_t        owner, owner_n;
  logic        fwait, fwait_n;
  logic [3:0]  cnt, cnt_n;
  logic [31:0] addr_n, dtw_n, dtrf_n, dtre_n;
  logic        rw_n, stb_n;
  logic        ackf_n, acke_n, stlf_n, stle_n;
  logic        starve;

  assign starve = fwait && (cnt == SMAX);

  always_comb begin
    state_n = state;
    owner_n = owner;
    fwait_n = fwait;
    cnt_n   = cnt;
    addr_n  = addr;
    dtw_n   = dtw;
    rw_n    = rw;
    dtrf_n  = dtrf;
    dtre_n  = dtre;
    stb_n   = 1'b0;
    ackf_n  = 1'b0;
    acke_n  = 1'b0;
    stlf_n  = 1'b0;
    stle_n  = 1'b0;
    case (state)
      IDLE: begin
        if (stbe && !starve) begin
          state_n = BUSY;
          owner_n = OWN_E;
          stb_n   = 1'b1;
          addr_n  = addre;
          dtw_n   = dtwe;
          rw_n    = rwe;
          if (fwait && cnt != 4'hf)
            cnt_n = cnt + 4'd1;
          if (stbf) begin
            stlf_n  = 1'b1;
            fwait_n = 1'b1;
          end
        end else if (stbf) begin
          state_n = BUSY;
          owner_n = OWN_F;
          stb_n   = 1'b1;
          addr_n  = addrf;
          dtw_n   = '0;
          rw_n    = 1'b0;
          fwait_n = 1'b0;
          cnt_n   = '0;
          stle_n  = stbe;
        end else begin
          stle_n = stbe;
        end
      end
      BUSY: begin
        // Any strobe during a transaction is rejected, even from the owner.
        stle_n = stbe;
        if (stbf) begin
          stlf_n  = 1'b1;
          fwait_n = 1'b1;
        end
        if (stl) begin
          state_n = IDLE;
          if (owner == OWN_E) stle_n = 1'b1;
          else                stlf_n = 1'b1;
        end else if (ack) begin
          state_n = IDLE;
          if (owner == OWN_E) begin
            acke_n = 1'b1;
            dtre_n = dtr;
          end else begin
            ackf_n = 1'b1;
            dtrf_n = dtr;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      owner <= OWN_F;
      fwait <= 1'b0;
      cnt   <= '0;
      addr  <= '0;
      dtw   <= '0;
      rw    <= 1'b0;
      stb   <= 1'b0;
      dtrf  <= '0;
      dtre  <= '0;
      ackf  <= 1'b0;
      acke  <= 1'b0;
      stlf  <= 1'b0;
      stle  <= 1'b0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      fwait <= fwait_n;
      cnt   <= cnt_n;
      addr  <= addr_n;
      dtw   <= dtw_n;
      rw    <= rw_n;
      stb   <= stb_n;
      dtrf  <= dtrf_n;
      dtre  <= dtre_n;
      ackf  <= ackf_n;
      acke  <= acke_n;
      stlf  <= stlf_n;
      stle  <= stle_n;
    end
  end

endmodule

// File: tb/tb_hs32_mem_arbiter.sv
// Bench for hs32_mem_arbiter: directed scenarios plus random traffic
// compared cycle by cycle against a transaction-level reference model.
module tb_hs32_mem_arbiter;

  localparam int SMAX = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addrf, addre, dtwe, dtr;
  logic        stbf, stbe, rwe, ack, stl;
  logic [31:0] dtrf, dtre, addr, dtw;
  logic        ackf, stlf, acke, stle, rw, stb;

  int n_cmp = 0;
  int n_err = 0;
  int ne = 0;
  int nf = 0;

  logic [31:0] x_addr, x_dtw, x_dtrf, x_dtre;
  logic        x_rw, x_stb, x_ackf, x_acke, x_stlf, x_stle;
  bit m_busy, m_owner_e, m_wait;
  int m_grants;

  hs32_mem_arbiter #(.STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .addrf(addrf), .stbf(stbf), .dtrf(dtrf), .ackf(ackf), .stlf(stlf),
    .addre(addre), .dtwe(dtwe), .rwe(rwe), .stbe(stbe),
    .dtre(dtre), .acke(acke), .stle(stle),
    .addr(addr), .dtw(dtw), .rw(rw), .stb(stb),
    .dtr(dtr), .ack(ack), .stl(stl)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic issue(input bit e);
    x_stb     = 1'b1;
    x_addr    = e ? addre : addrf;
    x_dtw     = e ? dtwe : 32'h0;
    x_rw      = e ? rwe : 1'b0;
    m_owner_e = e;
    m_busy    = 1'b1;
  endtask

  // Reference: one decision per clock edge from the current inputs.
  task automatic model_step();
    x_stb = 0; x_ackf = 0; x_acke = 0; x_stlf = 0; x_stle = 0;
    if (!reset) begin
      x_addr = 0; x_dtw = 0; x_rw = 0; x_dtrf = 0; x_dtre = 0;
      m_busy = 0; m_wait = 0; m_grants = 0;
    end else if (!m_busy) begin
      if (stbe && !(m_wait && m_grants >= SMAX)) begin
        if (m_wait) m_grants++;
        issue(1);
        if (stbf) begin x_stlf = 1; m_wait = 1; end
      end else if (stbf) begin
        issue(0);
        m_wait = 0; m_grants = 0;
        if (stbe) x_stle = 1;
      end else if (stbe) begin
        x_stle = 1;
      end
    end else begin
      if (stbf) begin x_stlf = 1; m_wait = 1; end
      if (stbe) x_stle = 1;
      if (stl) begin
        if (m_owner_e) x_stle = 1; else x_stlf = 1;
        m_busy = 0;
      end else if (ack) begin
        if (m_owner_e) begin x_acke = 1; x_dtre = dtr; end
        else begin x_ackf = 1; x_dtrf = dtr; end
        m_busy = 0;
      end
    end
  endtask

  task automatic check_all();
    chk("addr", addr, x_addr);
    chk("dtw", dtw, x_dtw);
    chk("rw", 32'(rw), 32'(x_rw));
    chk("stb", 32'(stb), 32'(x_stb));
    chk("dtrf", dtrf, x_dtrf);
    chk("dtre", dtre, x_dtre);
    chk("ackf", 32'(ackf), 32'(x_ackf));
    chk("acke", 32'(acke), 32'(x_acke));
    chk("stlf", 32'(stlf), 32'(x_stlf));
    chk("stle", 32'(stle), 32'(x_stle));
  endtask

  task automatic cyc(input bit f, input bit e, input bit w,
                     input bit a, input bit s, input bit r);
    stbf = f; stbe = e; rwe = w; ack = a; stl = s; reset = r;
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
    if (stb && rw) ne++;
    if (stb && !rw) nf++;
  endtask

  initial begin
    addrf = 0; addre = 0; dtwe = 0; dtr = 0;
    @(negedge clk);
    cyc(0, 0, 0, 0, 0, 0);
    chk("rst_stb", 32'(stb), 0);
    // Lone fetch read
    addrf = 32'h100;
    cyc(1, 0, 0, 0, 0, 1);
    chk("t1_addr", addr, 32'h100);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    dtr = 32'hDEADBEEF;
    cyc(0, 0, 0, 1, 0, 1);
    chk("t1_dtrf", dtrf, 32'hDEADBEEF);
    chk("t1_ackf", 32'(ackf), 1);
    // Contest, then starvation guard
    addre = 32'h2000; dtwe = 32'h55AA; addrf = 32'h300;
    ne = 0; nf = 0;
    for (int k = 0; k < 5; k++) begin
      cyc(1, 1, 1, 0, 0, 1);
      if (k == 0) chk("t2_stlf", 32'(stlf), 1);
      cyc(0, 0, 0, 1, 0, 1);
    end
    chk("t3_egrants", 32'(ne), 4);
    chk("t3_fgrants", 32'(nf), 1);
    cyc(0, 1, 1, 0, 0, 1);
    chk("t3_ewins", 32'(stb && rw), 1);
    // Strobe while busy, and strobe on the ack edge
    cyc(1, 0, 0, 0, 0, 1);
    chk("t4_stlf", 32'(stlf), 1);
    cyc(1, 0, 0, 1, 0, 1);
    chk("t4_stlf_ack", 32'(stlf), 1);
    // Memory stall then retry
    addrf = 32'h40;
    cyc(1, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1, 1);
    chk("t5_stlf", 32'(stlf), 1);
    cyc(1, 0, 0, 0, 0, 1);
    chk("t5_addr", addr, 32'h40);
    cyc(0, 0, 0, 1, 0, 1);
    // Reset mid-busy, late ack dropped
    cyc(0, 1, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("t6_addr", addr, 0);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 0, 1);
    chk("t6_acke", 32'(acke), 0);
    cyc(1, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 0, 1);
    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      bit f, e, a, s, r;
      addrf = $urandom; addre = $urandom;
      dtwe = $urandom; dtr = $urandom;
      f = $urandom_range(0, 1) == 1;
      e = $urandom_range(0, 2) != 0;
      if (m_busy && !m_owner_e) f = 0;
      if (m_busy && m_owner_e) e = 0;
      a = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      s = $urandom_range(0, 5) == 0;
      r = $urandom_range(0, 63) != 0;
      cyc(f, e, 1'($urandom_range(0, 1)), a, s, r);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
